// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: PC select, instruction-memory req/ack and decode valid/ready.
interface instruction_fetch_if #(
  parameter int ADDR_W  = 24,
  parameter int INSTR_W = 32
);
  logic [ADDR_W-1:0]  pc_in;
  logic [1:0]         pc_control;
  logic               redirect_valid;
  logic               redirect_is_jump;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr_data;
  logic [ADDR_W-1:0]  instr_pc;

  // Fetch stage side
  modport master (
    input  pc_in, redirect_valid, redirect_is_jump, imem_ack, imem_rdata, instr_ready,
    output pc_control, imem_req, imem_addr, instr_valid, instr_data, instr_pc
  );

  // PC / memory / decode side
  modport slave (
    output pc_in, redirect_valid, redirect_is_jump, imem_ack, imem_rdata, instr_ready,
    input  pc_control, imem_req, imem_addr, instr_valid, instr_data, instr_pc
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: one imem read per PC value, one-entry output register to decode,
// PC advanced only on a completed fetch or an execute redirect.
module instruction_fetch #(
  parameter int ADDR_W  = 24,
  parameter int INSTR_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  instruction_fetch_if.master bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DISCARD = 2'd2} state_t;

  state_t             state, state_nxt;
  logic               req_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               vld_q;
  logic [INSTR_W-1:0] data_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [1:0]         pc_sel;

  logic slot_free, issue, fill, done;

  // Slot is free when empty or being drained this cycle.
  assign slot_free = !vld_q || bus.instr_ready;
  // Never issue while redirecting: pc_in still holds the stale PC.
  assign issue     = (state == IDLE) && !bus.redirect_valid && slot_free;
  // Only a REQ-state ack without redirect delivers data; DISCARD acks are dropped.
  assign fill      = (state == REQ) && bus.imem_ack && !bus.redirect_valid;
  assign done      = (state == REQ || state == DISCARD) && bus.imem_ack;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (issue) state_nxt = REQ;
      REQ: begin
        if (bus.imem_ack)           state_nxt = IDLE;
        else if (bus.redirect_valid) state_nxt = DISCARD;
      end
      DISCARD: if (bus.imem_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // PC select: redirect wins in any state, otherwise increment on a delivered fetch
  always_comb begin
    pc_sel = 2'b00;
    if (reset)                   pc_sel = 2'b00;
    else if (bus.redirect_valid) pc_sel = {1'b1, bus.redirect_is_jump};
    else if (fill)               pc_sel = 2'b01;
  end

  // Request register and decode output register
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q  <= 1'b0;
      addr_q <= '0;
      vld_q  <= 1'b0;
      data_q <= '0;
      pc_q   <= '0;
    end else begin
      if (issue) begin
        req_q  <= 1'b1;
        addr_q <= bus.pc_in;
      end else if (done) begin
        req_q  <= 1'b0;
      end
      // The slot is always empty in REQ, so a fill never overwrites a live entry.
      if (fill) begin
        vld_q  <= 1'b1;
        data_q <= bus.imem_rdata;
        pc_q   <= addr_q;
      end else if (bus.redirect_valid || bus.instr_ready) begin
        vld_q  <= 1'b0;
      end
    end
  end

  assign bus.pc_control  = pc_sel;
  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = addr_q;
  assign bus.instr_valid = vld_q;
  assign bus.instr_data  = data_q;
  assign bus.instr_pc    = pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: PC register model, latency-programmable memory,
// directed scenarios plus a randomized run checked against program-order rules.
module tb_instruction_fetch;

  logic clk, reset;
  instruction_fetch_if #(.ADDR_W(24), .INSTR_W(32)) bus ();

  instruction_fetch #(.ADDR_W(24), .INSTR_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register model: reacts to pc_control, loads a chosen start value on reset
  logic [23:0] pc, pc_rst, br_tgt, jmp_tgt;
  always @(posedge clk) begin
    if (reset) pc <= pc_rst;
    else case (bus.pc_control)
      2'b01:   pc <= pc + 24'd1;
      2'b10:   pc <= br_tgt;
      2'b11:   pc <= jmp_tgt;
      default: pc <= pc;
    endcase
  end
  assign bus.pc_in = pc;

  // Memory model: ack after 'lat' waiting cycles, or manual ack when mem_auto=0
  function automatic logic [31:0] memf(input logic [23:0] a);
    return {a[7:0], a} ^ 32'h9E3779B9;
  endfunction

  int          lat, wcnt;
  logic        mem_auto, manual_ack, ovr_en;
  logic [23:0] ovr_addr;
  logic [31:0] ovr_data;
  always @(posedge clk) begin
    if (reset || !bus.imem_req || bus.imem_ack) wcnt <= 0;
    else                                        wcnt <= wcnt + 1;
  end
  assign bus.imem_ack   = mem_auto ? (bus.imem_req && wcnt >= lat) : manual_ack;
  assign bus.imem_rdata = (ovr_en && bus.imem_addr == ovr_addr) ? ovr_data : memf(bus.imem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [23:0] start);
    reset = 1'b1;
    bus.redirect_valid = 1'b0;
    pc_rst = start;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_is_jump = 1'b1;
    #1;
    tests++;
    if (bus.pc_control !== 2'b00) begin fails++; $display("FAIL rst_pcctl got %b exp 00", bus.pc_control); end
    tick();
    tick();
    tests++;
    if (bus.imem_req !== 1'b0 || bus.imem_addr !== 24'h0) begin
      fails++; $display("FAIL rst_req got req=%b addr=%h exp 0/000000", bus.imem_req, bus.imem_addr);
    end
    tests++;
    if (bus.instr_valid !== 1'b0 || bus.instr_data !== 32'h0 || bus.instr_pc !== 24'h0) begin
      fails++; $display("FAIL rst_out got v=%b d=%h pc=%h exp 0/0/0", bus.instr_valid, bus.instr_data, bus.instr_pc);
    end
    bus.redirect_valid = 1'b0;
    bus.redirect_is_jump = 1'b0;
  endtask

  task automatic test_first_fetch();
    ovr_en = 1'b1; ovr_addr = 24'h0; ovr_data = 32'hDEADBEEF;
    mem_auto = 1'b1; lat = 0; bus.instr_ready = 1'b1;
    do_reset(24'h000000);
    tick();
    tests++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 24'h0) begin
      fails++; $display("FAIL ff_req got req=%b addr=%h exp 1/000000", bus.imem_req, bus.imem_addr);
    end
    tests++;
    if (bus.pc_control !== 2'b01) begin fails++; $display("FAIL ff_pcctl got %b exp 01", bus.pc_control); end
    tick();
    tests++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 24'h0 || bus.instr_data !== 32'hDEADBEEF || bus.imem_req !== 1'b0) begin
      fails++; $display("FAIL ff_out got v=%b pc=%h d=%h req=%b exp 1/000000/deadbeef/0",
                        bus.instr_valid, bus.instr_pc, bus.instr_data, bus.imem_req);
    end
    tick();
    tests++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 24'h000001) begin
      fails++; $display("FAIL ff_next got req=%b addr=%h exp 1/000001", bus.imem_req, bus.imem_addr);
    end
    ovr_en = 1'b0;
  endtask

  task automatic test_latency();
    int incs;
    incs = 0;
    mem_auto = 1'b1; lat = 3; bus.instr_ready = 1'b1;
    do_reset(24'h000020);
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 24'h000020 || bus.pc_control !== 2'b00) begin
        fails++; $display("FAIL lat_wait%0d got req=%b addr=%h pcctl=%b exp 1/000020/00",
                          i, bus.imem_req, bus.imem_addr, bus.pc_control);
      end
      if (bus.pc_control == 2'b01) incs++;
    end
    tick();
    tests++;
    if (bus.pc_control !== 2'b01 || bus.imem_addr !== 24'h000020) begin
      fails++; $display("FAIL lat_ack got pcctl=%b addr=%h exp 01/000020", bus.pc_control, bus.imem_addr);
    end
    if (bus.pc_control == 2'b01) incs++;
    tick();
    if (bus.pc_control == 2'b01) incs++;
    tests++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 24'h000020 || bus.instr_data !== memf(24'h000020)) begin
      fails++; $display("FAIL lat_out got v=%b pc=%h d=%h exp 1/000020/%h",
                        bus.instr_valid, bus.instr_pc, bus.instr_data, memf(24'h000020));
    end
    tests++;
    if (incs != 1) begin fails++; $display("FAIL lat_inc_once got %0d exp 1", incs); end
  endtask

  task automatic test_backpressure();
    logic [31:0] d0;
    logic [23:0] p0;
    mem_auto = 1'b1; lat = 0; bus.instr_ready = 1'b0;
    do_reset(24'h000040);
    tick();
    tick();
    d0 = bus.instr_data; p0 = bus.instr_pc;
    tests++;
    if (bus.instr_valid !== 1'b1 || d0 !== memf(24'h000040) || p0 !== 24'h000040) begin
      fails++; $display("FAIL bp_fill got v=%b d=%h pc=%h exp 1/%h/000040", bus.instr_valid, d0, p0, memf(24'h000040));
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b1 || bus.instr_data !== d0 || bus.instr_pc !== p0) begin
        fails++; $display("FAIL bp_hold%0d got req=%b v=%b d=%h pc=%h exp 0/1/%h/%h",
                          i, bus.imem_req, bus.instr_valid, bus.instr_data, bus.instr_pc, d0, p0);
      end
    end
    bus.instr_ready = 1'b1;
    tick();
    tests++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 24'h000041 || bus.instr_valid !== 1'b0) begin
      fails++; $display("FAIL bp_resume got req=%b addr=%h v=%b exp 1/000041/0",
                        bus.imem_req, bus.imem_addr, bus.instr_valid);
    end
  endtask

  task automatic test_jump_discard();
    mem_auto = 1'b1; lat = 2; bus.instr_ready = 1'b1;
    ovr_en = 1'b1; ovr_addr = 24'h000010; ovr_data = 32'h12345678;
    do_reset(24'h000010);
    tick();
    tick();
    jmp_tgt = 24'h000300;
    bus.redirect_valid = 1'b1; bus.redirect_is_jump = 1'b1;
    #1;
    tests++;
    if (bus.pc_control !== 2'b11) begin fails++; $display("FAIL jd_pcctl got %b exp 11", bus.pc_control); end
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    tests++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 24'h000010 || bus.imem_ack !== 1'b1 || bus.pc_control !== 2'b00) begin
      fails++; $display("FAIL jd_discard got req=%b addr=%h ack=%b pcctl=%b exp 1/000010/1/00",
                        bus.imem_req, bus.imem_addr, bus.imem_ack, bus.pc_control);
    end
    tick();
    tests++;
    if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.instr_data === 32'h12345678) begin
      fails++; $display("FAIL jd_drop got req=%b v=%b d=%h exp 0/0/not 12345678",
                        bus.imem_req, bus.instr_valid, bus.instr_data);
    end
    tick();
    tests++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 24'h000300) begin
      fails++; $display("FAIL jd_target got req=%b addr=%h exp 1/000300", bus.imem_req, bus.imem_addr);
    end
    tick();
    tick();
    tick();
    tests++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 24'h000300 || bus.instr_data !== memf(24'h000300)) begin
      fails++; $display("FAIL jd_out got v=%b pc=%h d=%h exp 1/000300/%h",
                        bus.instr_valid, bus.instr_pc, bus.instr_data, memf(24'h000300));
    end
    ovr_en = 1'b0;
  endtask

  task automatic test_branch_flush();
    mem_auto = 1'b1; lat = 0; bus.instr_ready = 1'b0;
    do_reset(24'h000050);
    tick();
    tick();
    br_tgt = 24'h000700;
    bus.redirect_valid = 1'b1; bus.redirect_is_jump = 1'b0;
    #1;
    tests++;
    if (bus.pc_control !== 2'b10 || bus.instr_valid !== 1'b1) begin
      fails++; $display("FAIL bf_pcctl got pcctl=%b v=%b exp 10/1", bus.pc_control, bus.instr_valid);
    end
    tick();
    bus.redirect_valid = 1'b0;
    tests++;
    if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
      fails++; $display("FAIL bf_flush got v=%b req=%b exp 0/0", bus.instr_valid, bus.imem_req);
    end
    tick();
    tests++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 24'h000700) begin
      fails++; $display("FAIL bf_target got req=%b addr=%h exp 1/000700", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_reset_mid_req();
    mem_auto = 1'b0; manual_ack = 1'b0; bus.instr_ready = 1'b1;
    do_reset(24'h000060);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    manual_ack = 1'b1;
    #1;
    tests++;
    if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.pc_control !== 2'b00) begin
      fails++; $display("FAIL rm_drop got req=%b v=%b pcctl=%b exp 0/0/00",
                        bus.imem_req, bus.instr_valid, bus.pc_control);
    end
    tick();
    manual_ack = 1'b0;
    #1;
    tests++;
    if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 24'h000060 || bus.pc_control !== 2'b00) begin
      fails++; $display("FAIL rm_late_ack got v=%b req=%b addr=%h pcctl=%b exp 0/1/000060/00",
                        bus.instr_valid, bus.imem_req, bus.imem_addr, bus.pc_control);
    end
    mem_auto = 1'b1;
  endtask

  // Randomized run: accepted instructions must follow program order (pc+1, or the
  // latest redirect target), carry the memory word for their pc, and both the
  // output register and the outstanding request must hold steady while stalled.
  task automatic test_random();
    logic [23:0] expect_pc, p_pc, p_addr;
    logic [31:0] p_data;
    logic        p_hold, p_wait;
    int          accepted;
    accepted = 0; p_hold = 1'b0; p_wait = 1'b0; p_pc = '0; p_addr = '0; p_data = '0;
    mem_auto = 1'b1; ovr_en = 1'b0; lat = 1; bus.instr_ready = 1'b1;
    do_reset(24'hFFFFF0);
    expect_pc = 24'hFFFFF0;
    for (int n = 0; n < 3000; n++) begin
      tick();
      if (p_hold) begin
        tests++;
        if (bus.instr_valid !== 1'b1 || bus.instr_data !== p_data || bus.instr_pc !== p_pc) begin
          fails++; $display("FAIL rnd_stall c%0d got v=%b d=%h pc=%h exp 1/%h/%h",
                            n, bus.instr_valid, bus.instr_data, bus.instr_pc, p_data, p_pc);
        end
      end
      if (p_wait) begin
        tests++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== p_addr) begin
          fails++; $display("FAIL rnd_reqhold c%0d got req=%b addr=%h exp 1/%h", n, bus.imem_req, bus.imem_addr, p_addr);
        end
      end
      lat = $urandom_range(0, 3);
      bus.instr_ready = ($urandom_range(0, 9) < 7);
      bus.redirect_valid = ($urandom_range(0, 11) == 0);
      bus.redirect_is_jump = $urandom_range(0, 1);
      br_tgt  = ($urandom_range(0, 3) == 0) ? 24'hFFFFFE : 24'($urandom);
      jmp_tgt = ($urandom_range(0, 3) == 0) ? 24'hFFFFFD : 24'($urandom);
      #1;
      if (bus.redirect_valid) begin
        tests++;
        if (bus.pc_control !== {1'b1, bus.redirect_is_jump}) begin
          fails++; $display("FAIL rnd_pcctl c%0d got %b exp %b", n, bus.pc_control, {1'b1, bus.redirect_is_jump});
        end
      end
      if (bus.instr_valid && bus.instr_ready) begin
        accepted++;
        tests++;
        if (bus.instr_pc !== expect_pc || bus.instr_data !== memf(bus.instr_pc)) begin
          fails++; $display("FAIL rnd_order c%0d got pc=%h d=%h exp %h/%h",
                            n, bus.instr_pc, bus.instr_data, expect_pc, memf(expect_pc));
        end
        expect_pc = bus.instr_pc + 24'd1;
      end
      if (bus.redirect_valid) expect_pc = bus.redirect_is_jump ? jmp_tgt : br_tgt;
      p_hold = bus.instr_valid && !bus.instr_ready && !bus.redirect_valid;
      p_data = bus.instr_data;
      p_pc   = bus.instr_pc;
      p_wait = bus.imem_req && !bus.imem_ack;
      p_addr = bus.imem_addr;
    end
    bus.redirect_valid = 1'b0;
    tests++;
    if (accepted < 200) begin fails++; $display("FAIL rnd_progress got %0d accepted exp >=200", accepted); end
  endtask

  initial begin
    reset = 1'b1;
    pc_rst = '0; br_tgt = '0; jmp_tgt = '0;
    lat = 0; mem_auto = 1'b1; manual_ack = 1'b0;
    ovr_en = 1'b0; ovr_addr = '0; ovr_data = '0;
    bus.redirect_valid = 1'b0; bus.redirect_is_jump = 1'b0; bus.instr_ready = 1'b0;
    test_reset();
    test_first_fetch();
    test_latency();
    test_backpressure();
    test_jump_discard();
    test_branch_flush();
    test_reset_mid_req();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly downstream of the program counter.
- Issues one instruction-memory read per PC value over a req/ack handshake, which tolerates variable memory latency.
- Presents the fetched word plus its address to decode through a one-entry valid/ready output register.
- Drives the PC's 2-bit select (hold/increment/branch/jump) so the PC advances only when a fetch completes, or when execute redirects.

Parameters:
ADDR_W, 24, width of PC and instruction-memory address
INSTR_W, 32, instruction word width

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
pc_in  input  ADDR_W  current PC value (PC register output)
pc_control  output  2  PC select: 00 hold, 01 increment, 10 branch, 11 jump
redirect_valid  input  1  execute requests a control transfer this cycle
redirect_is_jump  input  1  qualifies redirect: 0 branch, 1 jump
imem_req  output  1  memory read request (registered)
imem_addr  output  ADDR_W  read address, stable while imem_req high (registered)
imem_ack  input  1  read complete; imem_rdata valid this cycle
imem_rdata  input  INSTR_W  read data
instr_valid  output  1  output register holds an instruction
instr_ready  input  1  decode accepts instruction
instr_data  output  INSTR_W  fetched instruction
instr_pc  output  ADDR_W  address the instruction was fetched from

Behaviour:
- Single clock domain. Reset is synchronous and active-high, with priority over everything. On reset: state=IDLE, imem_req=0, imem_addr=0, instr_valid=0, instr_data=0, instr_pc=0. pc_control is forced to 00 while reset is high.
- pc_control is combinational:
  - 10/11 whenever redirect_valid=1 (per redirect_is_jump), in any state.
  - Otherwise 01 in a REQ cycle with imem_ack=1.
  - Otherwise 00.
- State IDLE:
  - Issue condition: redirect_valid=0 and slot free (instr_valid=0, or instr_valid=1 with instr_ready=1).
  - When met: next edge imem_addr<=pc_in, imem_req<=1, go to REQ.
  - Never issues in a redirect cycle; the PC has not yet taken the new value.
  - imem_ack is ignored in IDLE.
- State REQ (imem_req=1, imem_addr held):
  - ack=1, no redirect: instr_data<=imem_rdata, instr_pc<=imem_addr, instr_valid<=1, imem_req<=0, go to IDLE.
  - ack=1 with redirect: data dropped, imem_req<=0, go to IDLE.
  - ack=0 with redirect: go to DISCARD with imem_req kept high.
  - ack=0, no redirect: stay in REQ.
- State DISCARD:
  - imem_req stays high with the same address until ack.
  - On ack the data is dropped, imem_req<=0, go to IDLE.
  - Further redirects here only drive pc_control and stay in DISCARD.
- Output register:
  - Handshake completes when instr_valid && instr_ready. If no new fill arrives, instr_valid<=0 next edge.
  - instr_data/instr_pc stay stable while instr_valid && !instr_ready.
  - redirect_valid=1 clears instr_valid next edge (flush), regardless of instr_ready.
  - Slot is guaranteed empty throughout REQ, so a fill never overwrites.
- Throughput: at most one instruction per 2 cycles (IDLE, REQ with ack same cycle). Latency from issue edge to instr_valid = memory ack latency + 1 cycle.
- Address arithmetic: none internally. PC wrap from all-ones to 0 is the PC's concern; fetch just uses pc_in.
- Reset mid-request: imem_req drops immediately. The instruction memory must tolerate an abandoned request, and a late ack arriving in IDLE is ignored.

Test Plan:
- Reset, then pc_in=0x000000, memory acks same cycle as req with 0xDEADBEEF, instr_ready=1 -> imem_req=1 with addr 0x000000 in cycle 2; pc_control=01 that cycle; instr_valid=1, instr_pc=0x000000, instr_data=0xDEADBEEF next cycle; next req to 0x000001.
- Memory latency 3 cycles -> imem_req/imem_addr held stable 3 cycles; pc_control=00 until the ack cycle, then 01 exactly once.
- instr_ready=0 for 4 cycles with instr_valid=1 -> no new imem_req issued; instr_data/instr_pc unchanged; issue resumes in the cycle instr_ready rises.
- redirect_valid=1, redirect_is_jump=1, one cycle after req to 0x000010 (ack 2 cycles later) -> pc_control=11 that cycle; state DISCARD; acked data 0x12345678 never appears on instr_data; next req uses the jump target from pc_in.
- redirect_valid=1, redirect_is_jump=0 while instr_valid=1, instr_ready=0 -> pc_control=10; instr_valid=0 next edge; no req issued in the redirect cycle.
- reset asserted while in REQ -> next edge imem_req=0, instr_valid=0; ack on the following cycle is ignored; pc_control=00.
